// File: rtl/adapter_rtl_pkg.sv
// Shared types and configuration constants for the adapter memory link.
package adapter_rtl_pkg;

    localparam int unsigned PKG_ADDR_W  = 8;
    localparam int unsigned PKG_DATA_W  = 32;
    localparam int unsigned PKG_BE_W    = PKG_DATA_W / 8;
    localparam int unsigned LATENCY_MIN = 1;
    localparam int unsigned LATENCY_MAX = 4;

    typedef struct packed {
        logic                  we;
        logic [PKG_ADDR_W-1:0] addr;
        logic [PKG_DATA_W-1:0] wdata;
        logic [PKG_BE_W-1:0]   be;
    } req_t;

    typedef struct packed {
        logic                  write;
        logic                  err;
        logic [PKG_DATA_W-1:0] rdata;
    } rsp_t;

    // Latency must be in range and the response buffer must cover every in-flight stage.
    function automatic logic cfg_ok(input int unsigned latency, input int unsigned rsp_depth);
        return (latency >= LATENCY_MIN) && (latency <= LATENCY_MAX) && (rsp_depth >= latency);
    endfunction

endpackage

// File: rtl/adapter_rsp_fifo.sv
// First-word-fall-through response FIFO; the head is driven straight from storage.
module adapter_rsp_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       valid,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q + CNT_W'(push) - CNT_W'(pop);
        if (push) wptr_d = ptr_inc(wptr_q);
        if (pop)  rptr_d = ptr_inc(rptr_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage is not reset; an empty FIFO presents an all-zero head instead.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= wdata;
    end

    assign valid = (cnt_q != '0);
    assign rdata = valid ? mem_q[rptr_q] : '0;
    assign count = cnt_q;

endmodule

// File: rtl/adapter_mem_responder.sv
// Memory-side responder: services requests from a word array and returns
// in-order responses after a fixed latency, with credit-based backpressure.
module adapter_mem_responder
    import adapter_rtl_pkg::*;
#(
    parameter int unsigned ADDR_W    = PKG_ADDR_W,
    parameter int unsigned DATA_W    = PKG_DATA_W,
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned LATENCY   = 2,
    parameter int unsigned RSP_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_write,
    output logic                rsp_err
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int unsigned RSP_W = $bits(rsp_t);

    if (!cfg_ok(LATENCY, RSP_DEPTH) || (ADDR_W != PKG_ADDR_W) || (DATA_W != PKG_DATA_W) ||
        ((DATA_W % 8) != 0) || (DEPTH > (2 ** ADDR_W))) begin : g_bad_cfg
        $error("adapter_mem_responder: illegal parameter set");
    end

    req_t             req_c;
    rsp_t             new_rsp_c;
    logic             accept_c;
    logic             consume_c;
    logic             err_c;
    logic [CNT_W-1:0] out_now_c;
    logic [CNT_W-1:0] out_d;

    logic [LATENCY-1:0] vld_q, vld_d;
    rsp_t               stage_q [LATENCY];
    rsp_t               stage_d [LATENCY];
    logic               ready_q, ready_d;

    logic [DATA_W-1:0] mem_q [DEPTH];

    rsp_t             fifo_rdata;
    logic             fifo_valid;
    logic [CNT_W-1:0] fifo_count;

    // Request decode, pipeline shift and credit computation.
    always_comb begin
        req_c.we    = req_we;
        req_c.addr  = req_addr;
        req_c.wdata = req_wdata;
        req_c.be    = req_be;

        accept_c  = req_valid & ready_q;
        consume_c = fifo_valid & rsp_ready;
        err_c     = (ADDR_W + 1)'(req_c.addr) >= (ADDR_W + 1)'(DEPTH);

        new_rsp_c.write = req_c.we;
        new_rsp_c.err   = err_c;
        new_rsp_c.rdata = (req_c.we || err_c) ? '0 : mem_q[req_c.addr];

        vld_d    = vld_q;
        stage_d  = stage_q;
        vld_d[0] = accept_c;
        stage_d[0] = accept_c ? new_rsp_c : '0;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            vld_d[i]   = vld_q[i-1];
            stage_d[i] = stage_q[i-1];
        end

        out_now_c = fifo_count;
        for (int unsigned i = 0; i < LATENCY; i++) begin
            out_now_c = out_now_c + CNT_W'(vld_q[i]);
        end
        out_d   = out_now_c + CNT_W'(accept_c) - CNT_W'(consume_c);
        ready_d = (out_d < CNT_W'(RSP_DEPTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q   <= '0;
            ready_q <= 1'b0;
            for (int unsigned i = 0; i < LATENCY; i++) stage_q[i] <= '0;
        end else begin
            vld_q   <= vld_d;
            ready_q <= ready_d;
            stage_q <= stage_d;
        end
    end

    // Byte-masked array write at the acceptance edge; contents survive reset.
    always_ff @(posedge clk) begin
        if (accept_c && req_c.we && !err_c) begin
            for (int unsigned b = 0; b < BE_W; b++) begin
                if (req_c.be[b]) mem_q[req_c.addr][b*8 +: 8] <= req_c.wdata[b*8 +: 8];
            end
        end
    end

    adapter_rsp_fifo #(
        .WIDTH (RSP_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (vld_q[LATENCY-1]),
        .wdata (stage_q[LATENCY-1]),
        .pop   (consume_c),
        .rdata (fifo_rdata),
        .valid (fifo_valid),
        .count (fifo_count)
    );

    assign req_ready = ready_q;
    assign rsp_valid = fifo_valid;
    assign rsp_rdata = fifo_rdata.rdata;
    assign rsp_write = fifo_rdata.write;
    assign rsp_err   = fifo_rdata.err;

endmodule

// File: tb/tb_adapter_mem_responder.sv
// Randomized and directed bench for adapter_mem_responder against a queue-based reference model.
module tb_adapter_mem_responder;

    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned DEPTH     = 200;
    localparam int unsigned LAT       = 2;
    localparam int unsigned RSP_DEPTH = 4;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [3:0]        req_be;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_write;
    logic              rsp_err;

    adapter_mem_responder #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .LATENCY   (LAT),
        .RSP_DEPTH (RSP_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_write (rsp_write),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          write;
        bit          err;
        bit          known;
        logic [31:0] rdata;
        int          acc;
    } exp_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          head_vis = 0;
    exp_t        exp_q[$];
    logic [31:0] mdl_mem [256];
    bit          mdl_known [256];
    logic [31:0] last_rd;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: writes merge by byte enable, reads see the array at acceptance, out-of-range is an error.
    task automatic model_accept();
        exp_t e;
        int   a;
        a       = int'(req_addr);
        e.acc   = cyc;
        e.write = req_we;
        e.err   = (a >= int'(DEPTH));
        e.known = 1'b1;
        e.rdata = '0;
        if (!e.err && !req_we) begin
            e.known = mdl_known[a];
            e.rdata = mdl_mem[a];
        end
        if (!e.err && req_we) begin
            for (int b = 0; b < 4; b++)
                if (req_be[b]) mdl_mem[a][b*8 +: 8] = req_wdata[b*8 +: 8];
            mdl_known[a] = mdl_known[a] || (req_be == 4'hF);
        end
        if (exp_q.size() == 0) head_vis = cyc + int'(LAT);
        exp_q.push_back(e);
    endtask

    task automatic sample_check();
        bit ev;
        ev = (exp_q.size() > 0) && (cyc >= head_vis);
        check_eq("rsp_valid", rsp_valid, ev);
        check_eq("req_ready", req_ready, exp_q.size() < int'(RSP_DEPTH));
        if (ev && rsp_valid) begin
            check_eq("rsp_write", rsp_write, exp_q[0].write);
            check_eq("rsp_err", rsp_err, exp_q[0].err);
            if (exp_q[0].known) check_eq("rsp_rdata", rsp_rdata, exp_q[0].rdata);
        end
    endtask

    // One clock: note handshakes before the edge, update the model, check after the falling edge.
    task automatic step(output bit acc);
        bit          con;
        logic [31:0] rd_now;
        acc    = req_valid && req_ready;
        con    = rsp_valid && rsp_ready;
        rd_now = rsp_rdata;
        @(posedge clk);
        cyc++;
        if (con && exp_q.size() > 0) begin
            last_rd = rd_now;
            void'(exp_q.pop_front());
            if (exp_q.size() > 0) head_vis = (exp_q[0].acc + int'(LAT) > cyc) ? exp_q[0].acc + int'(LAT) : cyc;
        end
        if (acc) model_accept();
        @(negedge clk);
        sample_check();
    endtask

    task automatic send(input bit we, input int addr, input logic [31:0] wd, input logic [3:0] be,
                        output int n);
        bit acc;
        n         = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = ADDR_W'(addr);
        req_wdata = wd;
        req_be    = be;
        do begin
            step(acc);
            n++;
        end while (!acc && n < 200);
        check_eq("send_accept", acc, 1'b1);
    endtask

    task automatic idle();
        req_valid = 1'b0;
    endtask

    task automatic drain();
        bit acc;
        int n = 0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        while (exp_q.size() > 0 && n < 200) begin
            step(acc);
            n++;
        end
        check_eq("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        bit acc;
        int n;
        int n_acc;
        int total;

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; req_be = '0; rsp_ready = 1'b0; last_rd = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_req_ready", req_ready, 1'b0);
        check_eq("rst_rsp_valid", rsp_valid, 1'b0);
        check_eq("rst_rsp_rdata", rsp_rdata, 32'h0);
        check_eq("rst_rsp_write", rsp_write, 1'b0);
        check_eq("rst_rsp_err", rsp_err, 1'b0);
        rst = 1'b0;
        step(acc);

        // Write then read back, exact latency tracked by the model.
        rsp_ready = 1'b1;
        send(1'b1, 'h10, 32'hDEADBEEF, 4'hF, n);
        send(1'b0, 'h10, 32'h0, 4'h0, n);
        drain();
        check_eq("wr_rd_data", last_rd, 32'hDEADBEEF);

        // Partial byte-enable merge.
        send(1'b1, 'h20, 32'h11223344, 4'hF, n);
        send(1'b1, 'h20, 32'hAABBCCDD, 4'h5, n);
        send(1'b0, 'h20, 32'h0, 4'h0, n);
        drain();
        check_eq("be_merge", last_rd, 32'h11BB33DD);

        // Out-of-range accesses and no aliasing onto low addresses.
        send(1'b1, 'h37, 32'h5555AAAA, 4'hF, n);
        send(1'b1, 'h7F, 32'h12345678, 4'hF, n);
        send(1'b0, 'hC8, 32'h0, 4'h0, n);
        send(1'b1, 'hFF, 32'hCAFEF00D, 4'hF, n);
        send(1'b0, 'hFF, 32'h0, 4'h0, n);
        send(1'b0, 'h37, 32'h0, 4'h0, n);
        send(1'b0, 'h7F, 32'h0, 4'h0, n);
        drain();
        check_eq("no_alias", last_rd, 32'h12345678);

        // Credit exhaustion under backpressure, then in-order drain.
        for (int a = 0; a < 8; a++) send(1'b1, a, 32'hA000_0000 + 32'(a), 4'hF, n);
        drain();
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = '0;
        n_acc = 0;
        repeat (8) begin
            step(acc);
            if (acc) begin
                n_acc++;
                req_addr = req_addr + 8'd1;
            end
        end
        check_eq("credit_accepts", n_acc, 4);
        check_eq("full_ready_low", req_ready, 1'b0);
        rsp_ready = 1'b1;
        step(acc);
        rsp_ready = 1'b0;
        check_eq("ready_after_consume", req_ready, 1'b1);
        rsp_ready = 1'b1;
        for (int a = 4; a < 8; a++) send(1'b0, a, 32'h0, 4'h0, n);
        drain();
        check_eq("last_in_order", last_rd, 32'hA000_0007);

        // Streaming: one acceptance per cycle.
        rsp_ready = 1'b1;
        total = 0;
        for (int i = 0; i < 32; i++) begin
            send(1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)), $urandom,
                 4'($urandom_range(1, 15)), n);
            total += n;
        end
        check_eq("stream_cycles", total, 32);
        drain();

        // Random traffic with random backpressure.
        repeat (400) begin
            req_valid = ($urandom_range(0, 9) < 6);
            req_we    = 1'($urandom_range(0, 1));
            req_addr  = ADDR_W'($urandom_range(0, 255));
            req_wdata = $urandom;
            req_be    = 4'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 1) == 1);
            step(acc);
        end
        drain();

        // Reset with responses buffered; array contents must persist.
        send(1'b1, 'h30, 32'h0BADC0DE, 4'hF, n);
        drain();
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(1'b0, 'h30, 32'h0, 4'h0, n);
        idle();
        repeat (3) step(acc);
        #2 rst = 1'b1;
        #1;
        check_eq("async_rst_rsp_valid", rsp_valid, 1'b0);
        check_eq("async_rst_req_ready", req_ready, 1'b0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        rsp_ready = 1'b1;
        repeat (4) step(acc);
        send(1'b0, 'h30, 32'h0, 4'h0, n);
        drain();
        check_eq("persist_after_rst", last_rd, 32'h0BADC0DE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
